// File: rtl/key_packer.sv
// key_packer
//   Transmit-side front end of the hash pipeline. Packs a stream of 32-bit key
//   words into 128-bit chunks for the key FIFO (first byte at [7:0], unused
//   tail bytes zero). After the key's last chunk, it writes the key byte length
//   to the key-length FIFO. Keys longer than MAX_KEY_BYTES are truncated: the
//   length saturates and oOvf pulses with the length write.
//
//   Build option: define KEY_PACKER_BSWAP_EN to byte-swap each input word
//   before lane placement (byte 0 then comes from [31:24]).
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   iKeyData/iKeyValid    key word stream; oKeyReady accepts a word
//   iKeyLast/iKeyBytes    last-word marker and its valid byte count (0 = 4)
//   oWrKeyClk             key FIFO write clock (= clk)
//   iWrKeyFull            key FIFO full
//   oWrKeyFifo_en/oKey    key FIFO write pulse and chunk data
//   oWrKeyLenClk          length FIFO write clock (= clk)
//   iWrKeyLenFull         length FIFO full
//   oWrKeyLenFifo_en      length FIFO write pulse
//   oKeyLen/oOvf          key length in bytes, truncation flag
//
// States
//   S_FILL | accepting words into the chunk buffer
//   S_PUSH | chunk complete, waiting to write it to the key FIFO
//   S_LEN  | all chunks written, waiting to write the length
module key_packer #(
  parameter int FIFOWIDTH     = 128,
  parameter int MAX_KEY_BYTES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          iKeyData,
  input  logic                 iKeyValid,
  output logic                 oKeyReady,
  input  logic                 iKeyLast,
  input  logic [1:0]           iKeyBytes,
  output logic                 oWrKeyClk,
  input  logic                 iWrKeyFull,
  output logic                 oWrKeyFifo_en,
  output logic [FIFOWIDTH-1:0] oKey,
  output logic                 oWrKeyLenClk,
  input  logic                 iWrKeyLenFull,
  output logic                 oWrKeyLenFifo_en,
  output logic [7:0]           oKeyLen,
  output logic                 oOvf
);

  localparam int         MAX_CHUNKS = (MAX_KEY_BYTES + 15) / 16;
  localparam logic [8:0] BYTE_SAT   = 9'(MAX_KEY_BYTES + 1);

  typedef enum logic [1:0] {S_FILL, S_PUSH, S_LEN} state_t;

  state_t               state, stateNext;
  logic [FIFOWIDTH-1:0] buffer;
  logic [1:0]           wcnt;
  logic [4:0]           chunkCnt;
  logic [8:0]           byteCnt;
  logic                 lastSeen;

  logic [31:0]          keyWord, maskedWord;
  logic [2:0]           nBytes;
  logic [8:0]           wordBase, byteSum, byteNext;
  logic                 dropWord, truncated;

  assign oWrKeyClk    = clk;
  assign oWrKeyLenClk = clk;
  assign oKeyReady    = (state == S_FILL) && !rst;

  // Once MAX_CHUNKS chunks are written, further words only advance the count.
  assign dropWord  = (chunkCnt == 5'(MAX_CHUNKS));
  assign truncated = (byteCnt > 9'(MAX_KEY_BYTES));

  always_comb begin
`ifdef KEY_PACKER_BSWAP_EN
    keyWord = {iKeyData[7:0], iKeyData[15:8], iKeyData[23:16], iKeyData[31:24]};
`else
    keyWord = iKeyData;
`endif
    nBytes = 3'd4;
    if (iKeyLast && (iKeyBytes != 2'd0)) nBytes = {1'b0, iKeyBytes};
    // Absolute byte offset of this word within the key.
    wordBase   = {chunkCnt, wcnt, 2'b00};
    maskedWord = '0;
    // Keep a byte only if it is a valid tail byte and lies inside the
    // reportable length; everything else reads as zero.
    for (int j = 0; j < 4; j++) begin
      if ((3'(j) < nBytes) && ((10'(wordBase) + 10'(j)) < 10'(MAX_KEY_BYTES)))
        maskedWord[8*j +: 8] = keyWord[8*j +: 8];
    end
    // Saturate just past the limit so long keys cannot wrap the counter.
    byteSum  = byteCnt + 9'(nBytes);
    byteNext = (byteSum > BYTE_SAT) ? BYTE_SAT : byteSum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FILL;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_FILL: begin
        if (iKeyValid) begin
          if (dropWord) begin
            if (iKeyLast) stateNext = S_LEN;
          end else if (iKeyLast || (wcnt == 2'd3)) begin
            stateNext = S_PUSH;
          end
        end
      end
      S_PUSH:  if (!iWrKeyFull) stateNext = lastSeen ? S_LEN : S_FILL;
      S_LEN:   if (!iWrKeyLenFull) stateNext = S_FILL;
      default: stateNext = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer           <= '0;
      wcnt             <= '0;
      chunkCnt         <= '0;
      byteCnt          <= '0;
      lastSeen         <= 1'b0;
      oKey             <= '0;
      oKeyLen          <= '0;
      oWrKeyFifo_en    <= 1'b0;
      oWrKeyLenFifo_en <= 1'b0;
      oOvf             <= 1'b0;
    end else begin
      oWrKeyFifo_en    <= 1'b0;
      oWrKeyLenFifo_en <= 1'b0;
      oOvf             <= 1'b0;
      case (state)
        S_FILL: begin
          if (iKeyValid) begin
            byteCnt <= byteNext;
            if (iKeyLast) lastSeen <= 1'b1;
            if (!dropWord) begin
              buffer[{wcnt, 5'b00000} +: 32] <= maskedWord;
              wcnt <= wcnt + 2'd1;
            end
          end
        end
        S_PUSH: begin
          if (!iWrKeyFull) begin
            oKey          <= buffer;
            oWrKeyFifo_en <= 1'b1;
            buffer        <= '0;
            wcnt          <= '0;
            chunkCnt      <= chunkCnt + 5'd1;
          end
        end
        S_LEN: begin
          if (!iWrKeyLenFull) begin
            oKeyLen          <= truncated ? 8'(MAX_KEY_BYTES) : byteCnt[7:0];
            oWrKeyLenFifo_en <= 1'b1;
            oOvf             <= truncated;
            byteCnt          <= '0;
            chunkCnt         <= '0;
            wcnt             <= '0;
            lastSeen         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_packer.sv
module tb_key_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  iKeyData;
  logic         iKeyValid, oKeyReady, iKeyLast;
  logic [1:0]   iKeyBytes;
  logic         oWrKeyClk, iWrKeyFull, oWrKeyFifo_en;
  logic [127:0] oKey;
  logic         oWrKeyLenClk, iWrKeyLenFull, oWrKeyLenFifo_en;
  logic [7:0]   oKeyLen;
  logic         oOvf;

  always #5 clk = ~clk;

  key_packer dut (
    .clk(clk), .rst(rst),
    .iKeyData(iKeyData), .iKeyValid(iKeyValid), .oKeyReady(oKeyReady),
    .iKeyLast(iKeyLast), .iKeyBytes(iKeyBytes),
    .oWrKeyClk(oWrKeyClk), .iWrKeyFull(iWrKeyFull),
    .oWrKeyFifo_en(oWrKeyFifo_en), .oKey(oKey),
    .oWrKeyLenClk(oWrKeyLenClk), .iWrKeyLenFull(iWrKeyLenFull),
    .oWrKeyLenFifo_en(oWrKeyLenFifo_en), .oKeyLen(oKeyLen), .oOvf(oOvf)
  );

  int checks = 0;
  int errors = 0;
  bit bpRandom = 1'b0;

  logic [127:0] gotChunks[$];
  logic [7:0]   gotLen[$];
  logic         gotOvf[$];
  int           gotAt[$];

  logic [31:0]  keyW[$];
  logic [1:0]   keyLb;
  logic [127:0] expChunks[$];
  int           expLen;
  bit           expOvf;

  typedef struct packed {
    logic [2:0]       nw;
    logic [3:0][31:0] w;
    logic [1:0]       lb;
    logic [127:0]     expChunk;
    logic [7:0]       expLen;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: records every FIFO write, sampled 1 time unit after the edge.
  logic prevKeyEn = 1'b0, prevLenEn = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      if (oWrKeyFifo_en) gotChunks.push_back(oKey);
      if (oWrKeyLenFifo_en) begin
        gotLen.push_back(oKeyLen);
        gotOvf.push_back(oOvf);
        gotAt.push_back(gotChunks.size());
      end
      if (oOvf) check("ovf_with_len_write", 128'(oWrKeyLenFifo_en), 128'd1);
      if (prevKeyEn) check("key_en_one_cycle", 128'(oWrKeyFifo_en), 128'd0);
      if (prevLenEn) check("len_en_one_cycle", 128'(oWrKeyLenFifo_en), 128'd0);
    end
    prevKeyEn = oWrKeyFifo_en;
    prevLenEn = oWrKeyLenFifo_en;
  end

  task automatic tick();
    @(negedge clk);
    if (bpRandom) begin
      iWrKeyFull    = ($urandom_range(0, 3) == 0);
      iWrKeyLenFull = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic sendWord(input logic [31:0] d, input logic last, input logic [1:0] b);
    int n;
    iKeyData = d; iKeyLast = last; iKeyBytes = b; iKeyValid = 1'b1;
    n = 0;
    while (!oKeyReady && n < 500) begin tick(); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no ready, expected ready within 500 cycles");
    end
    tick();
    iKeyValid = 1'b0; iKeyLast = 1'b0;
  endtask

  task automatic sendKey();
    for (int i = 0; i < keyW.size(); i++) sendWord(keyW[i], (i == keyW.size() - 1), keyLb);
  endtask

  task automatic waitLen();
    int n = 0;
    while (gotLen.size() == 0 && n < 600) begin tick(); n++; end
    if (n >= 600) begin
      checks++; errors++;
      $display("FAIL len_timeout: got no length write, expected one within 600 cycles");
    end
  endtask

  // Reference: flatten the key to a byte list, truncate, then cut 16-byte chunks.
  task automatic computeExpected();
    logic [7:0]   kb[$];
    logic [31:0]  w;
    logic [127:0] c;
    int n, len, eff, nch, idx;
    expChunks.delete();
    for (int i = 0; i < keyW.size(); i++) begin
      w = keyW[i];
      n = 4;
      if (i == keyW.size() - 1 && keyLb != 2'd0) n = int'(keyLb);
      for (int j = 0; j < n; j++) begin
`ifdef KEY_PACKER_BSWAP_EN
        kb.push_back(w[31 - 8*j -: 8]);
`else
        kb.push_back(w[8*j +: 8]);
`endif
      end
    end
    len = kb.size();
    eff = (len > 255) ? 255 : len;
    nch = (len + 15) / 16;
    if (nch > 16) nch = 16;
    for (int ci = 0; ci < nch; ci++) begin
      c = '0;
      for (int b = 0; b < 16; b++) begin
        idx = 16*ci + b;
        if (idx < eff) c[8*b +: 8] = kb[idx];
      end
      expChunks.push_back(c);
    end
    expLen = eff;
    expOvf = (len > 255);
  endtask

  task automatic finishKey();
    int m;
    waitLen();
    computeExpected();
    check("chunk_count", 128'(gotChunks.size()), 128'(expChunks.size()));
    m = (gotChunks.size() < expChunks.size()) ? gotChunks.size() : expChunks.size();
    for (int i = 0; i < m; i++) check($sformatf("chunk%0d", i), gotChunks[i], expChunks[i]);
    check("len_write_count", 128'(gotLen.size()), 128'd1);
    if (gotLen.size() > 0) begin
      check("key_len", 128'(gotLen[0]), 128'(expLen));
      check("ovf_flag", 128'(gotOvf[0]), 128'(expOvf));
      check("len_after_chunks", 128'(gotAt[0]), 128'(expChunks.size()));
    end
    gotChunks.delete(); gotLen.delete(); gotOvf.delete(); gotAt.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_oKey"}, oKey, 128'd0);
    check({tag, "_oKeyLen"}, 128'(oKeyLen), 128'd0);
    check({tag, "_keyEn"}, 128'(oWrKeyFifo_en), 128'd0);
    check({tag, "_lenEn"}, 128'(oWrKeyLenFifo_en), 128'd0);
    check({tag, "_oOvf"}, 128'(oOvf), 128'd0);
    check({tag, "_ready"}, 128'(oKeyReady), 128'd0);
  endtask

  initial begin
    vecs[0] = '{nw: 3'd2, w: {32'h0, 32'h0, 32'h00000055, 32'h44332211}, lb: 2'd1,
                expChunk: 128'h0000_0055_4433_2211, expLen: 8'd5};
    vecs[1] = '{nw: 3'd4, w: {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100}, lb: 2'd0,
                expChunk: 128'h0F0E0D0C_0B0A0908_07060504_03020100, expLen: 8'd16};
    vecs[2] = '{nw: 3'd1, w: {32'h0, 32'h0, 32'h0, 32'hAABBCCDD}, lb: 2'd1,
                expChunk: 128'hDD, expLen: 8'd1};
    vecs[3] = '{nw: 3'd1, w: {32'h0, 32'h0, 32'h0, 32'h11223344}, lb: 2'd3,
                expChunk: 128'h223344, expLen: 8'd3};
    vecs[4] = '{nw: 3'd4, w: {32'hDEADBEEF, 32'h76543210, 32'h89ABCDEF, 32'h01234567}, lb: 2'd2,
                expChunk: 128'h0000BEEF_76543210_89ABCDEF_01234567, expLen: 8'd14};

    rst = 1'b1; iKeyData = '0; iKeyValid = 1'b0; iKeyLast = 1'b0; iKeyBytes = '0;
    iWrKeyFull = 1'b0; iWrKeyLenFull = 1'b0;
    tick(); tick();
    checkResetOutputs("reset");
    rst = 1'b0;
    tick();
    check("ready_after_reset", 128'(oKeyReady), 128'd1);

    for (int v = 0; v < 5; v++) begin
      keyW.delete();
      for (int i = 0; i < int'(vecs[v].nw); i++) keyW.push_back(vecs[v].w[i]);
      keyLb = vecs[v].lb;
      sendKey();
      waitLen();
`ifndef KEY_PACKER_BSWAP_EN
      if (gotChunks.size() > 0) check($sformatf("vec%0d_chunk", v), gotChunks[0], vecs[v].expChunk);
      if (gotLen.size() > 0) check($sformatf("vec%0d_len", v), 128'(gotLen[0]), 128'(vecs[v].expLen));
`endif
      finishKey();
    end

    // Key-FIFO back-pressure: chunk held for 10 cycles, then a single write.
    keyW = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
    keyLb = 2'd0;
    computeExpected();
    iWrKeyFull = 1'b1;
    sendKey();
    for (int i = 0; i < 10; i++) begin
      check("kfull_no_pulse", 128'(oWrKeyFifo_en), 128'd0);
      check("kfull_ready_low", 128'(oKeyReady), 128'd0);
      tick();
    end
    iWrKeyFull = 1'b0;
    tick();
    check("kfull_pulse", 128'(oWrKeyFifo_en), 128'd1);
    check("kfull_data", oKey, expChunks[0]);
    tick();
    check("kfull_pulse_end", 128'(oWrKeyFifo_en), 128'd0);
    check("kfull_data_held", oKey, expChunks[0]);
    finishKey();

    // Length-FIFO back-pressure: next key's word must wait for the length.
    keyW = '{32'h00C0FFEE};
    keyLb = 2'd0;
    iWrKeyLenFull = 1'b1;
    sendKey();
    iKeyData = 32'h0BADF00D; iKeyLast = 1'b1; iKeyBytes = 2'd2; iKeyValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("lfull_ready_low", 128'(oKeyReady), 128'd0);
      check("lfull_no_len", 128'(gotLen.size()), 128'd0);
    end
    iWrKeyLenFull = 1'b0;
    sendWord(32'h0BADF00D, 1'b1, 2'd2);
    check("len_before_next_word", 128'(gotLen.size()), 128'd1);
    finishKey();
    keyW = '{32'h0BADF00D};
    keyLb = 2'd2;
    finishKey();

    // Overflow: 70 full words (280 bytes).
    keyW.delete();
    for (int i = 0; i < 70; i++) keyW.push_back($urandom);
    keyLb = 2'd0;
    sendKey();
    waitLen();
    check("ovf_chunk_count", 128'(gotChunks.size()), 128'd16);
    if (gotChunks.size() == 16) check("ovf_byte255_zero", 128'(gotChunks[15][127:120]), 128'd0);
    if (gotLen.size() > 0) begin
      check("ovf_len_ff", 128'(gotLen[0]), 128'hFF);
      check("ovf_flag_set", 128'(gotOvf[0]), 128'd1);
    end
    finishKey();

    // Reset mid-key: partial key discarded, next key starts clean.
    sendWord(32'h12345678, 1'b0, 2'd0);
    sendWord(32'h9ABCDEF0, 1'b0, 2'd0);
    rst = 1'b1;
    #1;
    checkResetOutputs("midkey_reset");
    tick(); tick();
    rst = 1'b0;
    tick();
    keyW = '{32'hCAFEBABE};
    keyLb = 2'd3;
    sendKey();
    waitLen();
    if (gotChunks.size() > 0) check("post_reset_chunk", gotChunks[0], 128'hFEBABE);
    if (gotLen.size() > 0) check("post_reset_len", 128'(gotLen[0]), 128'd3);
    finishKey();

    // Randomized keys with random back-pressure on both FIFOs.
    bpRandom = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int nw;
      nw = (k % 10 == 9) ? int'($urandom_range(62, 70)) : int'($urandom_range(1, 20));
      keyW.delete();
      for (int i = 0; i < nw; i++) keyW.push_back($urandom);
      keyLb = 2'($urandom_range(0, 3));
      sendKey();
      finishKey();
    end
    bpRandom = 1'b0;
    iWrKeyFull = 1'b0;
    iWrKeyLenFull = 1'b0;
    repeat (20) tick();
    check("no_stray_chunks", 128'(gotChunks.size()), 128'd0);
    check("no_stray_lens", 128'(gotLen.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
